// File: rtl/pipe_stall_ctrl.sv
// Central stall controller for the 5-stage pipeline: merges ID/EX/MEM stall
// requests, sequences multi-cycle EX ops and counts PC-stall cycles.
module pipe_stall_ctrl #(
    parameter int CNT_W  = 6,
    parameter int PERF_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_stallreq_id,
    input  logic              i_stallreq_ex,
    input  logic              i_stallreq_mem,
    input  logic              i_mc_start,
    input  logic [CNT_W-1:0]  i_mc_len,
    input  logic              i_mc_cancel,
    input  logic              i_perf_clr,
    output logic [5:0]        o_stall,
    output logic              o_mc_busy,
    output logic [CNT_W-1:0]  o_mc_cnt,
    output logic              o_mc_done,
    output logic [PERF_W-1:0] o_stall_cnt
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  r_len;
    logic [PERF_W-1:0] r_stall_cnt;

    logic w_len_multi;
    logic w_last;
    logic w_seq_req;
    logic w_ex_req;

    assign w_len_multi = (i_mc_len >= CNT_W'(2));
    assign w_last      = (r_cnt == (r_len - CNT_W'(1)));
    assign w_ex_req    = i_stallreq_ex | w_seq_req;

    // Sequencer's own hold request; cancel and reset drop it immediately
    always_comb begin
        w_seq_req = 1'b0;
        case (r_state)
            ST_IDLE: w_seq_req = i_mc_start & w_len_multi;
            ST_RUN:  w_seq_req = ~w_last;
            default: w_seq_req = 1'b0;
        endcase
        if (i_mc_cancel || i_rst) begin
            w_seq_req = 1'b0;
        end else begin
            w_seq_req = w_seq_req;
        end
    end

    // Stall vector: a stage stalls itself and everything upstream; WB never stalls
    always_comb begin
        o_stall = 6'b000000;
        if (i_rst) begin
            o_stall = 6'b000000;
        end else if (i_stallreq_mem) begin
            o_stall = 6'b011111;
        end else if (w_ex_req) begin
            o_stall = 6'b001111;
        end else if (i_stallreq_id) begin
            o_stall = 6'b000111;
        end else begin
            o_stall = 6'b000000;
        end
    end

    // Sequencer status outputs; mc_done holds through MEM-stall freezes of the last cycle
    always_comb begin
        o_mc_done = 1'b0;
        o_mc_busy = 1'b0;
        o_mc_cnt  = {CNT_W{1'b0}};
        if (i_rst) begin
            o_mc_done = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: o_mc_done = i_mc_start & ~w_len_multi & ~i_mc_cancel;
                ST_RUN: begin
                    o_mc_done = w_last & ~i_mc_cancel;
                    o_mc_busy = 1'b1;
                    o_mc_cnt  = r_cnt;
                end
                default: o_mc_done = 1'b0;
            endcase
        end
    end

    // Multi-cycle op sequencer state
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= {CNT_W{1'b0}};
            r_len   <= {CNT_W{1'b0}};
        end else if (i_mc_cancel) begin
            r_state <= ST_IDLE;
            r_cnt   <= {CNT_W{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // A start under MEM stall is simply re-sampled next cycle
                    if (i_mc_start && w_len_multi && !i_stallreq_mem) begin
                        r_state <= ST_RUN;
                        r_len   <= i_mc_len;
                        r_cnt   <= CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (i_stallreq_mem) begin
                        r_cnt <= r_cnt;
                    end else if (w_last) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= {CNT_W{1'b0}};
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // Saturating count of cycles in which the PC is held
    always_ff @(posedge i_clk) begin
        if (i_rst || i_perf_clr) begin
            r_stall_cnt <= {PERF_W{1'b0}};
        end else if (o_stall[0] && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + PERF_W'(1);
        end
    end

    assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed self-checking bench for pipe_stall_ctrl; a narrow perf counter
// makes saturation reachable in a few cycles.
module tb_pipe_stall_ctrl;

    localparam int CNT_W  = 6;
    localparam int PERF_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              stallreq_id, stallreq_ex, stallreq_mem;
    logic              mc_start, mc_cancel, perf_clr;
    logic [CNT_W-1:0]  mc_len;
    logic [5:0]        stall;
    logic              mc_busy, mc_done;
    logic [CNT_W-1:0]  mc_cnt;
    logic [PERF_W-1:0] stall_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    pipe_stall_ctrl #(.CNT_W(CNT_W), .PERF_W(PERF_W)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_stallreq_id (stallreq_id),
        .i_stallreq_ex (stallreq_ex),
        .i_stallreq_mem(stallreq_mem),
        .i_mc_start    (mc_start),
        .i_mc_len      (mc_len),
        .i_mc_cancel   (mc_cancel),
        .i_perf_clr    (perf_clr),
        .o_stall       (stall),
        .o_mc_busy     (mc_busy),
        .o_mc_cnt      (mc_cnt),
        .o_mc_done     (mc_done),
        .o_stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stallreq_id = 1'b1; stallreq_ex = 1'b1; stallreq_mem = 1'b1;
        mc_start = 1'b1; mc_len = 6'd5; mc_cancel = 1'b0; perf_clr = 1'b0;

        // reset with everything requested
        tick(); tick();
        #1;
        chk("rst_stall", 32'(stall), 32'h00);
        chk("rst_busy", 32'(mc_busy), 32'd0);
        chk("rst_cnt", 32'(mc_cnt), 32'd0);
        chk("rst_done", 32'(mc_done), 32'd0);
        chk("rst_perf", 32'(stall_cnt), 32'd0);
        rst = 1'b0; stallreq_id = 1'b0; stallreq_ex = 1'b0; stallreq_mem = 1'b0; mc_start = 1'b0;
        #1 chk("post_rst_stall", 32'(stall), 32'h00);

        // priority merge
        stallreq_id = 1'b1;  #1 chk("id", 32'(stall), 32'h07);
        stallreq_ex = 1'b1;  #1 chk("id_ex", 32'(stall), 32'h0F);
        stallreq_mem = 1'b1; #1 chk("id_ex_mem", 32'(stall), 32'h1F);
        stallreq_id = 1'b0; stallreq_mem = 1'b0; #1 chk("ex", 32'(stall), 32'h0F);
        stallreq_ex = 1'b0;  #1 chk("none", 32'(stall), 32'h00);

        // 4-cycle op
        perf_clr = 1'b1; tick(); perf_clr = 1'b0;
        mc_start = 1'b1; mc_len = 6'd4; #1;
        chk("l4_t0_stall", 32'(stall), 32'h0F);
        chk("l4_t0_cnt", 32'(mc_cnt), 32'd0);
        chk("l4_t0_busy", 32'(mc_busy), 32'd0);
        chk("l4_t0_done", 32'(mc_done), 32'd0);
        tick(); mc_start = 1'b0; #1;
        chk("l4_t1_stall", 32'(stall), 32'h0F);
        chk("l4_t1_cnt", 32'(mc_cnt), 32'd1);
        chk("l4_t1_busy", 32'(mc_busy), 32'd1);
        chk("l4_t1_done", 32'(mc_done), 32'd0);
        tick(); #1;
        chk("l4_t2_stall", 32'(stall), 32'h0F);
        chk("l4_t2_cnt", 32'(mc_cnt), 32'd2);
        chk("l4_t2_done", 32'(mc_done), 32'd0);
        tick(); #1;
        chk("l4_t3_stall", 32'(stall), 32'h00);
        chk("l4_t3_cnt", 32'(mc_cnt), 32'd3);
        chk("l4_t3_busy", 32'(mc_busy), 32'd1);
        chk("l4_t3_done", 32'(mc_done), 32'd1);
        tick(); #1;
        chk("l4_t4_busy", 32'(mc_busy), 32'd0);
        chk("l4_t4_done", 32'(mc_done), 32'd0);
        chk("l4_perf", 32'(stall_cnt), 32'd3);

        // length 1 and 0 are single-cycle
        mc_start = 1'b1; mc_len = 6'd1; #1;
        chk("l1_stall", 32'(stall), 32'h00);
        chk("l1_done", 32'(mc_done), 32'd1);
        mc_len = 6'd0; #1;
        chk("l0_stall", 32'(stall), 32'h00);
        chk("l0_done", 32'(mc_done), 32'd1);
        tick(); #1;
        chk("l0_busy", 32'(mc_busy), 32'd0);
        mc_start = 1'b0;

        // 3-cycle op frozen by MEM stall at T+1
        mc_start = 1'b1; mc_len = 6'd3; #1;
        chk("l3_t0_stall", 32'(stall), 32'h0F);
        tick(); mc_start = 1'b0; stallreq_mem = 1'b1; #1;
        chk("l3_t1_stall", 32'(stall), 32'h1F);
        chk("l3_t1_cnt", 32'(mc_cnt), 32'd1);
        tick(); stallreq_mem = 1'b0; #1;
        chk("l3_t2_cnt", 32'(mc_cnt), 32'd1);
        chk("l3_t2_stall", 32'(stall), 32'h0F);
        chk("l3_t2_done", 32'(mc_done), 32'd0);
        tick(); #1;
        chk("l3_t3_cnt", 32'(mc_cnt), 32'd2);
        chk("l3_t3_done", 32'(mc_done), 32'd1);
        chk("l3_t3_stall", 32'(stall), 32'h00);
        tick(); #1;
        chk("l3_t4_done", 32'(mc_done), 32'd0);

        // MEM stall on the final cycle keeps mc_done asserted
        mc_start = 1'b1; mc_len = 6'd2; #1;
        tick(); mc_start = 1'b0; #1;
        chk("l2_last_done", 32'(mc_done), 32'd1);
        stallreq_mem = 1'b1; #1;
        chk("l2_hold_stall", 32'(stall), 32'h1F);
        tick(); #1;
        chk("l2_hold_busy", 32'(mc_busy), 32'd1);
        chk("l2_hold_done", 32'(mc_done), 32'd1);
        stallreq_mem = 1'b0;
        tick(); #1;
        chk("l2_end_busy", 32'(mc_busy), 32'd0);

        // counter saturation, then clear wins over increment
        stallreq_ex = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        chk("perf_sat", 32'(stall_cnt), 32'hF);
        perf_clr = 1'b1; tick(); #1;
        chk("perf_clr", 32'(stall_cnt), 32'd0);
        perf_clr = 1'b0; stallreq_ex = 1'b0;

        // cancel mid-op
        mc_start = 1'b1; mc_len = 6'd5; tick(); mc_start = 1'b0; tick();
        mc_cancel = 1'b1; #1;
        chk("cxl_stall", 32'(stall), 32'h00);
        chk("cxl_done", 32'(mc_done), 32'd0);
        tick(); mc_cancel = 1'b0; #1;
        chk("cxl_busy", 32'(mc_busy), 32'd0);
        chk("cxl_cnt", 32'(mc_cnt), 32'd0);
        chk("cxl_done2", 32'(mc_done), 32'd0);

        // cancel beats start in the same cycle
        mc_start = 1'b1; mc_len = 6'd3; mc_cancel = 1'b1; #1;
        chk("cxl_start_stall", 32'(stall), 32'h00);
        tick(); mc_start = 1'b0; mc_cancel = 1'b0; #1;
        chk("cxl_start_busy", 32'(mc_busy), 32'd0);

        // reset mid-op
        mc_start = 1'b1; mc_len = 6'd5; tick(); mc_start = 1'b0; tick();
        rst = 1'b1; #1;
        chk("rst_mid_stall", 32'(stall), 32'h00);
        tick(); rst = 1'b0; #1;
        chk("rst_mid_busy", 32'(mc_busy), 32'd0);
        chk("rst_mid_cnt", 32'(mc_cnt), 32'd0);
        chk("rst_mid_done", 32'(mc_done), 32'd0);
        chk("rst_mid_perf", 32'(stall_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
Central pipeline stall controller for the 5-stage MIPS32 core. It merges stall requests from ID, EX and MEM into the 6-bit stall vector that every pipeline register (pc, if_id, id_ex, ex_mem, mem_wb) consumes. It also owns the multi-cycle EX-operation sequencer (madd/msub/div-style ops), which holds EX and upstream stages for the programmed number of cycles. A saturating stall-cycle performance counter is included.

Parameters:
CNT_W, 6, width of the multi-cycle length and count fields (max op length 2^CNT_W-1)
PERF_W, 32, width of the stall-cycle performance counter

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  synchronous reset, active-high (`RstEnable)
stallreq_id  input  1  ID stage stall request (load-use etc.)
stallreq_ex  input  1  EX stage single-cycle stall request
stallreq_mem  input  1  MEM stage stall request
mc_start  input  1  EX holds a multi-cycle op this cycle
mc_len  input  CNT_W  total EX cycles the op needs
mc_cancel  input  1  abort the in-flight multi-cycle op (flush)
perf_clr  input  1  clear the stall-cycle counter
stall  output  6  [0]=PC [1]=IF [2]=ID [3]=EX [4]=MEM [5]=WB; 1=`Stop
mc_busy  output  1  sequencer in RUN state
mc_cnt  output  CNT_W  cycle index of the current multi-cycle op (0 on first cycle)
mc_done  output  1  final cycle of a multi-cycle op; EX result valid
stall_cnt  output  PERF_W  cycles with stall[0]=1, saturating

Behaviour:
- State: 1-bit FSM {IDLE, RUN}, registers cnt_q[CNT_W], len_q[CNT_W], stall_cnt.
- Reset (rst=1 at posedge): state=IDLE, cnt_q=0, len_q=0, stall_cnt=0. While rst=1, stall=6'b000000, mc_done=0, mc_busy=0 (combinational outputs forced).
- seq_req (internal, combinational), gated by ~mc_cancel and ~rst:
  - IDLE: mc_start & (mc_len>=2)
  - RUN: cnt_q != len_q-1
- ex_req = stallreq_ex | seq_req.
- stall priority, combinational, same cycle as requests:
  - stallreq_mem: 6'b011111
  - else ex_req: 6'b001111
  - else stallreq_id: 6'b000111
  - else: 6'b000000
  - stall[5] is never asserted.
- mc_cnt = cnt_q in RUN, 0 in IDLE.
- mc_done (combinational):
  - IDLE: mc_start & (mc_len<=1) & ~mc_cancel
  - RUN: (cnt_q==len_q-1) & ~mc_cancel
- mc_busy = (state==RUN).
- Transitions, evaluated in order:
  - mc_cancel=1 (any state): next IDLE, cnt_q<=0. Cancel overrides start in the same cycle.
  - IDLE, mc_start & mc_len>=2 & ~stallreq_mem: next RUN, len_q<=mc_len, cnt_q<=1.
  - IDLE, mc_start with stallreq_mem=1: stay IDLE. EX is frozen, so start is re-sampled next cycle.
  - IDLE, mc_len 0 or 1: treated as a single-cycle op; stay IDLE.
  - RUN, stallreq_mem=1: hold state and cnt_q. The EX op is frozen.
  - RUN, cnt_q < len_q-1: cnt_q<=cnt_q+1.
  - RUN, cnt_q==len_q-1 & ~stallreq_mem: next IDLE, cnt_q<=0. mc_done stays high across any MEM-stall hold cycles.
  - mc_start and mc_len are ignored while in RUN; len_q is latched once.
- Latency: an op of length L>=2 with no MEM stalls occupies EX for exactly L cycles. stall[3:0] is asserted for the first L-1 of them. mc_done is high on cycle L only.
- stall_cnt:
  - perf_clr=1: stall_cnt<=0 (takes priority over increment).
  - else if stall[0]=1 and stall_cnt != all-ones: increment.
  - Saturates at 2^PERF_W-1.
- Reset mid-RUN: returns to IDLE next edge; the op is lost. Upstream re-issue is the pipeline's responsibility.

Test Plan:
1. Assert rst with all request inputs and mc_start high (mc_len=5) -> stall=000000, mc_busy=0, mc_cnt=0, mc_done=0, stall_cnt=0. Release rst -> normal operation resumes next cycle.
2. Requests with mc_start=0: stallreq_id only -> stall=000111. id+ex -> 001111. id+ex+mem -> 011111. Ex only -> 001111. None -> 000000.
3. mc_start=1, mc_len=4 at cycle T, no other requests:
   - stall=001111 at T, T+1, T+2; stall=000000 at T+3.
   - mc_cnt=0,1,2,3 over T..T+3.
   - mc_busy=1 at T+1..T+3.
   - mc_done=1 only at T+3.
   - stall_cnt increments by 3.
4. mc_start with mc_len=1, then with mc_len=0 -> stall=000000, mc_done=1 in the same cycle, mc_busy stays 0.
5. mc_len=3 at T, stallreq_mem=1 at T+1 only:
   - stall=011111 at T+1.
   - mc_cnt=1 at T+1 and T+2, mc_cnt=2 at T+3.
   - mc_done=1 only at T+3.
   - Preload stall_cnt to all-ones -> it stays all-ones; perf_clr -> 0.
6. mc_len=5 at T, mc_cancel=1 at T+2 -> stall=000000 at T+2, mc_done=0, mc_busy=0 and mc_cnt=0 at T+3. Repeat with rst instead of cancel at T+2 -> same state at T+3.
